// File: rtl/comms_pkg.sv
// Shared comms definitions: packet width, packet type field, tx_arbiter states
// and the odd-parity helper.
package comms_pkg;

    localparam int PKT_WIDTH = 54;

    typedef enum logic [1:0] {
        PKT_EVENT  = 2'd0,
        PKT_REG_WR = 2'd1,
        PKT_REG_RD = 2'd2,
        PKT_REPLY  = 2'd3
    } pkt_type_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } tx_state_e;

    // MSB becomes the XNOR of the payload bits, giving odd parity over the word.
    function automatic logic [PKT_WIDTH-1:0] apply_parity(input logic [PKT_WIDTH-1:0] word);
        logic [PKT_WIDTH-1:0] w;
        w = word;
        w[PKT_WIDTH-1] = ~^word[PKT_WIDTH-2:0];
        return w;
    endfunction

endpackage

// File: rtl/tx_arb_grant.sv
// Reply/event priority decision for tx_arbiter, with the consecutive-reply run
// counter that bounds event starvation.
module tx_arb_grant #(
    parameter int MAX_REPLY_RUN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic eval,
    input  logic reply_valid,
    input  logic fifo_empty,
    output logic grant_reply,
    output logic grant_event
);

    localparam int RUN_W = $clog2(MAX_REPLY_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_REPLY_RUN);

    logic [RUN_W-1:0] run;

    always_comb begin
        grant_reply = 1'b0;
        grant_event = 1'b0;
        if (eval) begin
            if (reply_valid && ((run < RUN_MAX) || fifo_empty)) begin
                grant_reply = 1'b1;
            end else if (!fifo_empty) begin
                grant_event = 1'b1;
            end
        end
    end

    // Saturates so a long reply burst with an empty FIFO still yields to the next event.
    always_ff @(posedge clk) begin
        if (reset) begin
            run <= '0;
        end else if (grant_reply) begin
            if (run != RUN_MAX) begin
                run <= run + 1'b1;
            end
        end else if (grant_event) begin
            run <= '0;
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Shares uart_tx between comms reply packets and event FIFO packets.
// Optional TX_ARB_PARITY_EN: forces odd parity into the packet MSB on latch.
module tx_arbiter
    import comms_pkg::*;
#(
    parameter int WIDTH         = PKT_WIDTH,
    parameter int MAX_REPLY_RUN = 4,
    parameter int BUSY_TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reply_valid,
    input  logic [WIDTH-1:0] reply_data,
    output logic             reply_ready,
    input  logic             fifo_empty,
    output logic             read_fifo_n,
    input  logic [WIDTH-1:0] fifo_data,
    output logic [WIDTH-1:0] tx_data,
    output logic             ld_tx_data,
    input  logic             tx_busy,
    output logic             timeout_err,
    input  logic             err_clear,
    output logic [15:0]      pkt_count
);

    // state        | meaning
    // ST_IDLE      | waiting for uart_tx idle, arbitrates reply vs event
    // ST_FETCH     | FIFO read data valid, latch it
    // ST_LOAD      | ld_tx_data strobe, arm busy timeout
    // ST_WAIT_BUSY | waiting for tx_busy to rise
    // ST_WAIT_DONE | waiting for tx_busy to fall

    localparam int TMO_W = $clog2(BUSY_TIMEOUT);
    // Down-counter runs through the WAIT_BUSY cycles that follow LOAD; terminal count is zero.
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(BUSY_TIMEOUT - 2);

    tx_state_e        state, state_nxt;
    logic             grant_eval, grant_reply, grant_event;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             latch_en;
    logic [WIDTH-1:0] latch_src, latch_word;

    assign grant_eval = (state == ST_IDLE) && !tx_busy && !reset;

    tx_arb_grant #(
        .MAX_REPLY_RUN(MAX_REPLY_RUN)
    ) u_grant (
        .clk         (clk),
        .reset       (reset),
        .eval        (grant_eval),
        .reply_valid (reply_valid),
        .fifo_empty  (fifo_empty),
        .grant_reply (grant_reply),
        .grant_event (grant_event)
    );

    assign latch_en  = grant_reply || (state == ST_FETCH);
    assign latch_src = (state == ST_FETCH) ? fifo_data : reply_data;

`ifdef TX_ARB_PARITY_EN
    assign latch_word = apply_parity(latch_src);
`else
    assign latch_word = latch_src;
`endif

    always_comb begin
        state_nxt   = state;
        reply_ready = 1'b0;
        read_fifo_n = 1'b1;
        ld_tx_data  = 1'b0;
        tmo_hit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_reply) begin
                    reply_ready = 1'b1;
                    state_nxt   = ST_LOAD;
                end else if (grant_event) begin
                    read_fifo_n = 1'b0;
                    state_nxt   = ST_FETCH;
                end
            end
            ST_FETCH: state_nxt = ST_LOAD;
            ST_LOAD: begin
                ld_tx_data = 1'b1;
                state_nxt  = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (tmo_cnt == '0) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // An in-flight packet caught by reset must not emit any strobe.
        if (reset) begin
            reply_ready = 1'b0;
            read_fifo_n = 1'b1;
            ld_tx_data  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            tx_data <= '0;
        end else begin
            state <= state_nxt;
            if (latch_en) begin
                tx_data <= latch_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == ST_LOAD) begin
            tmo_cnt <= TMO_LOAD;
        end else if ((state == ST_WAIT_BUSY) && (tmo_cnt != '0)) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_err <= 1'b0;
            pkt_count   <= '0;
        end else begin
            if (err_clear) begin
                timeout_err <= 1'b0;
            end else if (tmo_hit) begin
                timeout_err <= 1'b1;
            end
            if ((state == ST_WAIT_DONE) && !tx_busy) begin
                pkt_count <= pkt_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter with behavioural reply source, event FIFO
// and uart_tx models; honours TX_ARB_PARITY_EN when defined.
`timescale 1ns/1ps
module tb_tx_arbiter;
    import comms_pkg::*;

    localparam int W       = PKT_WIDTH;
    localparam int MAX_RUN = 4;
    localparam int TMO     = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         reply_valid = 1'b0;
    logic [W-1:0] reply_data = '0;
    logic         reply_ready;
    logic         fifo_empty = 1'b1;
    logic         read_fifo_n;
    logic [W-1:0] fifo_data = '0;
    logic [W-1:0] tx_data;
    logic         ld_tx_data;
    logic         tx_busy = 1'b0;
    logic         timeout_err;
    logic         err_clear = 1'b0;
    logic [15:0]  pkt_count;

    tx_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .reply_valid (reply_valid),
        .reply_data  (reply_data),
        .reply_ready (reply_ready),
        .fifo_empty  (fifo_empty),
        .read_fifo_n (read_fifo_n),
        .fifo_data   (fifo_data),
        .tx_data     (tx_data),
        .ld_tx_data  (ld_tx_data),
        .tx_busy     (tx_busy),
        .timeout_err (timeout_err),
        .err_clear   (err_clear),
        .pkt_count   (pkt_count)
    );

    always #5 clk = ~clk;

    // ---------------- environment models ----------------
    logic [W-1:0] rq[$];
    logic [W-1:0] fq[$];
    logic [W-1:0] rxq[$];
    logic [W-1:0] exp_q[$];
    int cyc = 0, ld_cyc = -1, grant_cyc = -1, ld_count = 0, fifo_reads = 0, viol = 0;
    int busy_left = 0, busy_len = 3;
    bit uart_dead = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            if (reply_ready || !read_fifo_n || ld_tx_data) viol++;
            tx_busy   <= 1'b0;
            busy_left = 0;
        end else begin
            if (reply_ready) begin
                grant_cyc = cyc;
                if (rq.size() > 0) void'(rq.pop_front());
                else viol++;
            end
            if (!read_fifo_n) begin
                grant_cyc = cyc;
                fifo_reads++;
                if (fq.size() > 0) fifo_data <= fq.pop_front();
                else viol++;
            end
            if (ld_tx_data) begin
                ld_cyc = cyc;
                ld_count++;
                if (tx_busy) viol++;
                rxq.push_back(tx_data);
                if (!uart_dead) begin
                    busy_left = busy_len;
                    tx_busy   <= 1'b1;
                end
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) tx_busy <= 1'b0;
            end
        end
        cyc++;
        reply_valid <= (rq.size() != 0);
        reply_data  <= (rq.size() != 0) ? rq[0] : '0;
        fifo_empty  <= (fq.size() == 0);
    end

    // ---------------- checking helpers ----------------
    int checks = 0, fails = 0;
    int model_run = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] exp_word(input logic [W-1:0] w);
        logic [W-1:0] r;
        bit p;
        r = w;
        p = 1'b1;
`ifdef TX_ARB_PARITY_EN
        for (int i = 0; i < W - 1; i++) p ^= w[i];
        r[W-1] = p;
`endif
        return r;
    endfunction

    function automatic logic [W-1:0] make_word(input bit rnd, input int idx, input pkt_type_e t);
        logic [W-1:0] w;
        if (rnd) w = W'({$urandom(), $urandom()});
        else     w = W'(64'(idx) << 8) | W'(64'h0000_0A00_0000_0000);
        w[1:0] = t;
        return w;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_data"},     tx_data, '0);
        check({tag, "_ld_tx_data"},  ld_tx_data, 0);
        check({tag, "_read_fifo_n"}, read_fifo_n, 1);
        check({tag, "_reply_ready"}, reply_ready, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_pkt_count"},   pkt_count, 0);
    endtask

    task automatic wait_pkts(input int target, input int budget);
        int n = 0;
        while (pkt_count != 16'(target) && n < budget) begin
            tick();
            n++;
        end
        check("pkt_count_reached", pkt_count, 64'(target));
    endtask

    task automatic wait_ld(input int l0, input int budget);
        int n = 0;
        while (ld_count == l0 && n < budget) begin
            tick();
            n++;
        end
        check("ld_seen", ld_count != l0, 1);
    endtask

    // Queues nr replies and ne events at once and predicts the transmit order
    // from the arbitration rule: replies win unless MAX_RUN replies in a row
    // already went out while an event is waiting.
    task automatic plan(input int nr, input int ne, input bit rnd);
        logic [W-1:0] r[$];
        logic [W-1:0] e[$];
        logic [W-1:0] w;
        for (int i = 0; i < nr; i++) begin
            w = make_word(rnd, i, PKT_REPLY);
            r.push_back(w);
            rq.push_back(w);
        end
        for (int i = 0; i < ne; i++) begin
            w = make_word(rnd, 100 + i, PKT_EVENT);
            e.push_back(w);
            fq.push_back(w);
        end
        while (r.size() > 0 || e.size() > 0) begin
            if (r.size() > 0 && (model_run < MAX_RUN || e.size() == 0)) begin
                exp_q.push_back(exp_word(r.pop_front()));
                model_run = (model_run < MAX_RUN) ? model_run + 1 : MAX_RUN;
            end else begin
                exp_q.push_back(exp_word(e.pop_front()));
                model_run = 0;
            end
        end
    endtask

    task automatic run_group(input string tag, input int nr, input int ne, input bit rnd);
        int p0 = int'(pkt_count);
        rxq.delete();
        exp_q.delete();
        plan(nr, ne, rnd);
        wait_pkts(p0 + nr + ne, 3000);
        check({tag, "_rx_count"}, rxq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rxq.size(); i++)
            check({tag, "_word"}, rxq[i], exp_q[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        model_run = 0;
        tick();
    endtask

    typedef struct {
        bit           is_reply;
        logic [W-1:0] data;
        int           lat;
    } vec_t;

    vec_t vt[6];

    initial begin
        int p0, l0, r0, n;
        logic [W-1:0] e1, e2;

        vt[0] = '{1'b1, 54'h2A_5A03_12,           1};
        vt[1] = '{1'b0, 54'h1_0000_0041,          2};
        vt[2] = '{1'b1, 54'h3F_FFFF_FFFF_FFFF,    1};
        vt[3] = '{1'b0, 54'h0,                    2};
        vt[4] = '{1'b0, 54'h20_0000_0000_0003,    2};
        vt[5] = '{1'b1, 54'h1F_FFFF_FFFF_FFFF,    1};

        tick(3);
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            p0 = int'(pkt_count);
            l0 = ld_count;
            rxq.delete();
            if (vt[i].is_reply) rq.push_back(vt[i].data);
            else                fq.push_back(vt[i].data);
            wait_pkts(p0 + 1, 200);
            check("vec_ld_once", ld_count - l0, 1);
            check("vec_latency", ld_cyc - grant_cyc, vt[i].lat);
            check("vec_rx_count", rxq.size(), 1);
            if (rxq.size() > 0) check("vec_word", rxq[0], exp_word(vt[i].data));
        end

        do_reset();
        run_group("starve", 10, 3, 1'b0);

        for (int k = 0; k < 4; k++) begin
            int nr, ne;
            nr = $urandom_range(0, 8);
            ne = $urandom_range(0, 5);
            if (nr + ne == 0) nr = 1;
            busy_len = $urandom_range(1, 5);
            run_group("rand", nr, ne, 1'b1);
        end
        busy_len = 3;

        // busy timeout
        uart_dead = 1'b1;
        p0 = int'(pkt_count);
        l0 = ld_count;
        rq.push_back(make_word(1'b1, 0, PKT_REPLY));
        wait_ld(l0, 50);
        n = 0;
        while (!timeout_err && n < 200) begin
            tick();
            n++;
        end
        check("tmo_err_set", timeout_err, 1);
        check("tmo_delay", cyc - ld_cyc, TMO);
        check("tmo_pkt_count", pkt_count, 64'(p0));
        tick(5);
        check("tmo_sticky", timeout_err, 1);
        uart_dead = 1'b0;
        run_group("tmo_recover", 1, 0, 1'b1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("tmo_cleared", timeout_err, 0);

        // err_clear in the same cycle as the timeout set wins
        uart_dead = 1'b1;
        p0 = int'(pkt_count);
        l0 = ld_count;
        rq.push_back(make_word(1'b1, 1, PKT_REPLY));
        wait_ld(l0, 50);
        n = 0;
        while (cyc < ld_cyc + TMO - 1 && n < 100) begin
            tick();
            n++;
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("clr_priority", timeout_err, 0);
        tick(3);
        check("clr_priority_hold", timeout_err, 0);
        check("clr_pkt_count", pkt_count, 64'(p0));
        uart_dead = 1'b0;
        run_group("clr_recover", 1, 1, 1'b1);

        // reset while waiting for tx_busy to fall
        busy_len = 20;
        e1 = make_word(1'b1, 0, PKT_EVENT);
        e2 = make_word(1'b1, 1, PKT_EVENT);
        fq.push_back(e1);
        fq.push_back(e2);
        n = 0;
        while (!tx_busy && n < 50) begin
            tick();
            n++;
        end
        check("mid_busy_seen", tx_busy, 1);
        tick(3);
        r0 = fifo_reads;
        l0 = ld_count;
        rxq.delete();
        reset = 1'b1;
        tick();
        check_reset_outputs("midrst");
        check("midrst_no_read", fifo_reads, r0);
        check("midrst_no_ld", ld_count, l0);
        reset = 1'b0;
        model_run = 0;
        busy_len = 3;
        wait_pkts(1, 200);
        check("midrst_rx_count", rxq.size(), 1);
        if (rxq.size() > 0) check("midrst_word", rxq[rxq.size()-1], exp_word(e2));
        check("midrst_reads", fifo_reads, r0 + 1);

        check("protocol_violations", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, got stuck expected completion");
        $fatal(1, "watchdog");
    end

endmodule
